fmin_reduce: RTL and testbench

- Streaming single-precision minimum reducer; the min-side counterpart of the FPU's combinational max unit.
- Consumes a vector of `len` IEEE-754 binary32 values over a valid/ready input stream.
- Tracks the running minimum and its element index, then presents one result on a valid/ready output stream.
- Sits in the FPU reduction path, alongside the future fmax reducer.

---
 rtl/fmin_reduce.sv | 77 +++++++
 tb/tb_fmin_reduce.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fmin_reduce.sv
// fmin_reduce: streaming binary32 minimum reducer with index, valid/ready in and out
module fmin_reduce #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [LEN_W-1:0] out_index,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  state_t state;
  logic [LEN_W-1:0] len_q, cnt, min_idx, nxt_idx;
  logic [31:0] min_val, nxt_val;
  logic hs, in_nan, min_nan, less, take;
  assign in_ready = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign hs = in_valid & in_ready;
  // sign-magnitude order: negatives below positives, and a larger negative magnitude is smaller
  always_comb begin
    in_nan = &in_data[30:23] && |in_data[22:0];
    min_nan = &min_val[30:23] && |min_val[22:0];
    less = in_data[31] != min_val[31] ? in_data[31] :
           in_data[31] ? in_data[30:0] > min_val[30:0] : in_data[30:0] < min_val[30:0];
    take = !in_nan && (min_nan || less);
    nxt_val = take ? in_data : min_val;
    nxt_idx = take ? cnt : min_idx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
      cnt <= '0;
      min_val <= QNAN;
      min_idx <= '0;
      out_data <= '0;
      out_index <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (len != '0) begin
            state <= ACCUM;
            len_q <= len;
            cnt <= '0;
            min_val <= QNAN;
            min_idx <= '0;
          end else begin
            state <= DONE;
            out_data <= QNAN;
            out_index <= '0;
          end
        end
        ACCUM: if (hs) begin
          cnt <= cnt + 1'b1;
          min_val <= nxt_val;
          min_idx <= nxt_idx;
          if (cnt == len_q - 1'b1) begin
            state <= DONE;
            out_data <= nxt_val;
            out_index <= nxt_idx;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fmin_reduce.sv
// tb_fmin_reduce: directed checks of fmin_reduce with hand-computed results
module tb_fmin_reduce;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [7:0] len = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, busy;
  logic [31:0] out_data;
  logic [7:0] out_index;
  logic [31:0] vec [4];
  int total = 0, passes = 0;

  fmin_reduce #(.LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic go(input logic [7:0] l);
    start = 1;
    len = l;
    step();
    start = 0;
    chk("busy_after_start", {31'b0, busy}, 1);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      chk("in_ready_accum", {31'b0, in_ready}, 1);
      in_valid = 1;
      in_data = vec[i];
      step();
      chk("out_valid_timing", {31'b0, out_valid}, (i == n - 1) ? 1 : 0);
    end
    in_valid = 0;
    in_data = 32'hFF80_0000;
  endtask

  task automatic result(input string tag, input logic [31:0] d, input logic [7:0] idx);
    chk({tag, "_valid"}, {31'b0, out_valid}, 1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_index"}, {24'b0, out_index}, {24'b0, idx});
    out_ready = 1;
    step();
    out_ready = 0;
    chk({tag, "_idle"}, {30'b0, busy, out_valid}, 0);
  endtask

  initial begin
    step();
    step();
    chk("rst_ready", {31'b0, in_ready}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", {24'b0, out_index}, 0);
    rst = 0;
    in_valid = 1;
    step();
    chk("idle_ignores_valid", {31'b0, busy}, 0);
    in_valid = 0;

    vec = '{32'h3F80_0000, 32'hC000_0000, 32'h3F00_0000, 32'h4040_0000};
    go(4); feed(4); result("basic", 32'hC000_0000, 1);

    vec = '{32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 0};
    go(3); feed(3); result("tie", 32'h3F00_0000, 0);

    vec = '{32'h0000_0000, 32'h8000_0000, 0, 0};
    go(2); feed(2); result("negzero", 32'h8000_0000, 1);

    vec = '{32'h7FC0_0000, 32'h7F80_0000, 32'hFF80_0000, 0};
    go(3); feed(3); result("inf", 32'hFF80_0000, 2);

    vec = '{32'h7FC0_0001, 32'h7FC0_0000, 0, 0};
    go(2); feed(2); result("allnan", 32'h7FC0_0000, 0);

    start = 1; len = 0;
    step();
    start = 0;
    result("len0", 32'h7FC0_0000, 0);

    go(3);
    in_valid = 1; in_data = 32'h4000_0000; step();
    in_valid = 0; in_data = 32'hFF80_0000; step();
    chk("stall_hold", {31'b0, out_valid}, 0);
    step();
    in_valid = 1; in_data = 32'h3F80_0000; step();
    chk("stall_two", {31'b0, out_valid}, 0);
    in_data = 32'hBF80_0000; step();
    in_valid = 0; in_data = 32'hFF80_0000;
    chk("stall_done", {31'b0, out_valid}, 1);
    chk("stall_data", out_data, 32'hBF80_0000);
    chk("stall_index", {24'b0, out_index}, 2);

    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      len = 5;
      step();
      chk("bp_valid", {31'b0, out_valid}, 1);
      chk("bp_data", out_data, 32'hBF80_0000);
      chk("bp_index", {24'b0, out_index}, 2);
    end
    start = 1; out_ready = 1;
    step();
    out_ready = 0;
    chk("bp_start_ignored", {31'b0, busy}, 0);
    start = 0;
    step();
    chk("bp_still_idle", {30'b0, busy, in_ready}, 0);

    vec = '{32'hC000_0000, 32'hC000_0000, 0, 0};
    go(4);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = vec[i]; step();
    end
    in_valid = 0;
    rst = 1;
    step();
    rst = 0;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_ready", {31'b0, in_ready}, 0);
    chk("abort_valid", {31'b0, out_valid}, 0);
    step();
    chk("abort_no_result", {31'b0, out_valid}, 0);

    vec = '{32'h4000_0000, 0, 0, 0};
    go(1); feed(1); result("after_rst", 32'h4000_0000, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
